// File: rtl/lif_array.sv
// rtl/lif_array.sv - time-multiplexed array of leaky integrate-and-fire neurons
//
// Purpose: N_NEURONS neurons share one update datapath. Each accepted input
// event updates one neuron (leak, integrate, threshold, refractory) and the
// result is presented one cycle later in a single-entry output register.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous reset, active HIGH despite the name
//   in_valid   - input event valid
//   in_ready   - input event accepted when in_valid & in_ready
//   in_idx     - target neuron index
//   in_current - unsigned input current
//   thr_wr     - threshold write strobe
//   thr_data   - new shared threshold
//   out_valid  - result valid
//   out_ready  - result consumed when out_valid & out_ready
//   out_idx    - neuron index of the result
//   out_spike  - neuron fired on this event
//   out_state  - membrane value after the update

module lif_array #(
    parameter int N_NEURONS   = 4,
    parameter int WIDTH       = 8,
    parameter int LEAK_SHIFT  = 1,
    parameter int REFRAC      = 2,
    parameter int RESET_MODE  = 0,
    parameter int THRESH_INIT = 200,
    parameter int IW          = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    in_idx,
    input  logic [WIDTH-1:0] in_current,
    input  logic             thr_wr,
    input  logic [WIDTH-1:0] thr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_idx,
    output logic             out_spike,
    output logic [WIDTH-1:0] out_state
);

    localparam logic [IW:0]      N_LIM     = N_NEURONS[IW:0];
    localparam logic [3:0]       REFRAC_V  = REFRAC[3:0];
    localparam logic [WIDTH-1:0] THR_RST   = THRESH_INIT[WIDTH-1:0];
    localparam logic [WIDTH:0]   SAT_MAX   = {1'b0, {WIDTH{1'b1}}};

    logic [WIDTH-1:0] v_q [N_NEURONS];
    logic [3:0]       r_q [N_NEURONS];
    logic [WIDTH-1:0] thr_q;

    logic             out_valid_q;
    logic [IW-1:0]    out_idx_q;
    logic             out_spike_q;
    logic [WIDTH-1:0] out_state_q;

    logic             accept;
    logic             idx_ok;
    logic             upd_en;
    logic [WIDTH-1:0] cur_v;
    logic [3:0]       cur_r;
    logic [WIDTH-1:0] leak;
    logic [WIDTH:0]   sum_raw;
    logic [WIDTH-1:0] sum_sat;
    logic             spike_d;
    logic [WIDTH-1:0] v_d;
    logic [3:0]       r_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // Out-of-range indices are swallowed: consumed but no update, no result.
    assign idx_ok   = ({1'b0, in_idx} < N_LIM);
    assign upd_en   = accept && idx_ok;

    always_comb begin
        cur_v   = '0;
        cur_r   = '0;
        leak    = '0;
        sum_raw = '0;
        sum_sat = '0;
        spike_d = 1'b0;
        v_d     = '0;
        r_d     = '0;
        if (idx_ok) begin
            cur_v = v_q[in_idx];
            cur_r = r_q[in_idx];
        end
        // A shift of zero means "no leak", not "leak everything".
        if (LEAK_SHIFT != 0) begin
            leak = cur_v >> LEAK_SHIFT;
        end
        sum_raw = {1'b0, cur_v - leak} + {1'b0, in_current};
        sum_sat = (sum_raw > SAT_MAX) ? {WIDTH{1'b1}} : sum_raw[WIDTH-1:0];
        if (cur_r != 4'd0) begin
            // Refractory: event only counts down, membrane frozen.
            r_d = cur_r - 4'd1;
            v_d = cur_v;
        end else if (sum_sat >= thr_q) begin
            spike_d = 1'b1;
            r_d     = REFRAC_V;
            v_d     = (RESET_MODE == 1) ? (sum_sat - thr_q) : '0;
        end else begin
            v_d = sum_sat;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_NEURONS; i++) begin
            if (rst_n) begin
                v_q[i] <= '0;
                r_q[i] <= '0;
            end else if (upd_en && ({1'b0, in_idx} == (IW+1)'(i))) begin
                v_q[i] <= v_d;
                r_q[i] <= r_d;
            end
        end
    end

    // The datapath reads thr_q before this edge, so a same-cycle event sees the old value.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            thr_q <= THR_RST;
        end else if (thr_wr) begin
            thr_q <= thr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_spike_q <= 1'b0;
            out_state_q <= '0;
        end else if (in_ready) begin
            out_valid_q <= upd_en;
            if (upd_en) begin
                out_idx_q   <= in_idx;
                out_spike_q <= spike_d;
                out_state_q <= v_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_spike = out_spike_q;
    assign out_state = out_state_q;

endmodule

// File: tb/tb_lif_array.sv
// tb/tb_lif_array.sv - directed self-checking bench for lif_array

module tb_lif_array;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_idx;
    logic [7:0] in_current;
    logic       thr_wr;
    logic [7:0] thr_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_idx;
    logic       out_spike;
    logic [7:0] out_state;

    logic       s_in_ready;
    logic       s_out_valid;
    logic [1:0] s_out_idx;
    logic       s_out_spike;
    logic [7:0] s_out_state;

    int checks;
    int failures;

    lif_array #(.N_NEURONS(4), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC(2),
                .RESET_MODE(0), .THRESH_INIT(200)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_current(in_current),
        .thr_wr(thr_wr), .thr_data(thr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_spike(out_spike), .out_state(out_state)
    );

    lif_array #(.N_NEURONS(4), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC(2),
                .RESET_MODE(1), .THRESH_INIT(200)) u_sub (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_idx(in_idx), .in_current(in_current),
        .thr_wr(thr_wr), .thr_data(thr_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_idx(s_out_idx), .out_spike(s_out_spike), .out_state(s_out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One event, result checked #1 after the accepting edge.
    task automatic ev(input string name, input logic [1:0] idx, input logic [7:0] cur,
                      input logic exp_spike, input logic [7:0] exp_state);
        @(negedge clk);
        in_valid = 1'b1; in_idx = idx; in_current = cur;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL %s in_ready got=%b exp=1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_idx, out_spike, out_state} !== {1'b1, idx, exp_spike, exp_state}) begin
            failures++;
            $display("FAIL %s got v=%b idx=%0d spk=%b st=%0d exp v=1 idx=%0d spk=%b st=%0d",
                     name, out_valid, out_idx, out_spike, out_state, idx, exp_spike, exp_state);
        end
    endtask

    task automatic wr_thr(input logic [7:0] t);
        @(negedge clk);
        thr_wr = 1'b1; thr_data = t;
        @(posedge clk); #1;
        thr_wr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; in_idx = 2'd1; in_current = 8'd255;
        thr_wr = 1'b1; thr_data = 8'd10;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0; in_valid = 1'b0; thr_wr = 1'b0;
        checks++;
        if ({out_valid, out_idx, out_spike, out_state, in_ready} !== {1'b0, 2'd0, 1'b0, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs got v=%b idx=%0d spk=%b st=%0d rdy=%b exp 0 0 0 0 1",
                     out_valid, out_idx, out_spike, out_state, in_ready);
        end
        checks++;
        if ({s_out_valid, s_in_ready} !== 2'b01) begin
            failures++; $display("FAIL reset_sub got v=%b rdy=%b exp v=0 rdy=1", s_out_valid, s_in_ready);
        end
    endtask

    task automatic test_integrate();
        ev("int_1", 2'd0, 8'd100, 1'b0, 8'd100);
        ev("int_2", 2'd0, 8'd100, 1'b0, 8'd150);
        ev("int_3", 2'd0, 8'd150, 1'b1, 8'd0);
        checks++;
        if ({s_out_spike, s_out_state} !== {1'b1, 8'd25}) begin
            failures++;
            $display("FAIL int_subtract got spk=%b st=%0d exp spk=1 st=25", s_out_spike, s_out_state);
        end
    endtask

    task automatic test_refractory();
        ev("refr_1", 2'd0, 8'd255, 1'b0, 8'd0);
        ev("refr_2", 2'd0, 8'd255, 1'b0, 8'd0);
        ev("refr_3", 2'd0, 8'd255, 1'b1, 8'd0);
    endtask

    task automatic test_saturation();
        // Write 255 in the same cycle as an event: the event still sees 200.
        @(negedge clk);
        thr_wr = 1'b1; thr_data = 8'd255;
        in_valid = 1'b1; in_idx = 2'd2; in_current = 8'd210;
        @(posedge clk); #1;
        thr_wr = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, out_spike, out_state} !== {1'b1, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL thr_old got v=%b spk=%b st=%0d exp v=1 spk=1 st=0", out_valid, out_spike, out_state);
        end
        ev("thr_new", 2'd1, 8'd250, 1'b0, 8'd250);
        ev("sat_clamp", 2'd1, 8'd255, 1'b1, 8'd0);
    endtask

    task automatic test_thr_zero();
        wr_thr(8'd0);
        ev("thr_zero", 2'd3, 8'd0, 1'b1, 8'd0);
        wr_thr(8'd200);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_idx = 2'd2; in_current = 8'd10;
        @(posedge clk); #1;
        in_idx = 2'd3; in_current = 8'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, out_idx, out_spike, out_state} !== {1'b0, 1'b1, 2'd2, 1'b0, 8'd0}) begin
                failures++;
                $display("FAIL bp_hold%0d got rdy=%b v=%b idx=%0d spk=%b st=%0d exp 0 1 2 0 0",
                         c, in_ready, out_valid, out_idx, out_spike, out_state);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_idx, out_state} !== {1'b1, 2'd3, 8'd0}) begin
            failures++; $display("FAIL b2b_1 got v=%b idx=%0d st=%0d exp 1 3 0", out_valid, out_idx, out_state);
        end
        in_idx = 2'd0; in_current = 8'd20;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_idx, out_state} !== {1'b1, 2'd0, 8'd0}) begin
            failures++; $display("FAIL b2b_2 got v=%b idx=%0d st=%0d exp 1 0 0", out_valid, out_idx, out_state);
        end
        in_idx = 2'd1; in_current = 8'd30;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_idx, out_state} !== {1'b1, 2'd1, 8'd0}) begin
            failures++; $display("FAIL b2b_3 got v=%b idx=%0d st=%0d exp 1 1 0", out_valid, out_idx, out_state);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_drain out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_independence();
        // Every neuron has one refractory count left on entry.
        ev("ind_r0", 2'd0, 8'd50, 1'b0, 8'd0);
        ev("ind_r1", 2'd1, 8'd60, 1'b0, 8'd0);
        ev("ind_r2", 2'd2, 8'd70, 1'b0, 8'd0);
        ev("ind_r3", 2'd3, 8'd80, 1'b0, 8'd0);
        ev("ind_a0", 2'd0, 8'd50, 1'b0, 8'd50);
        ev("ind_a1", 2'd1, 8'd60, 1'b0, 8'd60);
        ev("ind_a2", 2'd2, 8'd70, 1'b0, 8'd70);
        ev("ind_a3", 2'd3, 8'd80, 1'b0, 8'd80);
        ev("ind_b0", 2'd0, 8'd120, 1'b0, 8'd145);
        ev("ind_b2", 2'd2, 8'd200, 1'b1, 8'd0);
        ev("ind_b1", 2'd1, 8'd180, 1'b1, 8'd0);
        ev("ind_b3", 2'd3, 8'd100, 1'b0, 8'd140);
        ev("ind_c0", 2'd0, 8'd100, 1'b0, 8'd173);
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_idx = 2'd3; in_current = 8'd100;
        thr_wr = 1'b1; thr_data = 8'd50;
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; thr_wr = 1'b0;
        checks++;
        if ({out_valid, out_idx, out_spike, out_state, in_ready} !== {1'b0, 2'd0, 1'b0, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset got v=%b idx=%0d spk=%b st=%0d rdy=%b exp 0 0 0 0 1",
                     out_valid, out_idx, out_spike, out_state, in_ready);
        end
        ev("post_v0", 2'd0, 8'd199, 1'b0, 8'd199);
        ev("post_v3", 2'd3, 8'd0, 1'b0, 8'd0);
        ev("post_thr", 2'd2, 8'd60, 1'b0, 8'd60);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; in_current = '0;
        thr_wr = 1'b0; thr_data = '0; out_ready = 1'b1;
        test_reset();
        test_integrate();
        test_refractory();
        test_saturation();
        test_thr_zero();
        test_backpressure();
        test_independence();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lif_array.md
LIF_ARRAY -- requirements
Module: lif_array

Parameters
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- N_NEURONS, 4, number of neurons sharing one time-multiplexed update datapath (1..256).
- WIDTH, 8, membrane, current and threshold width in bits (4..16).
- LEAK_SHIFT, 1, leak per update equals v >> LEAK_SHIFT (0 = no leak).
- REFRAC, 2, input events ignored by a neuron after it spikes (0..15).
- RESET_MODE, 0, spike reset mode: 0 = reset to zero, 1 = subtract threshold.
- THRESH_INIT, 200, threshold value after reset.

Interface
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning (IW = max(1, clog2(N_NEURONS))):
- clk, in, 1, sole clock, all logic on its rising edge.
- rst_n, in, 1, synchronous active-high reset.
- in_valid, in, 1, input event valid.
- in_ready, out, 1, input event accepted when in_valid and in_ready are both high.
- in_idx, in, IW, target neuron.
- in_current, in, WIDTH, unsigned input current.
- thr_wr, in, 1, threshold write strobe.
- thr_data, in, WIDTH, new threshold.
- out_valid, out, 1, result valid.
- out_ready, in, 1, result consumed when out_valid and out_ready are both high.
- out_idx, out, IW, neuron index of the result.
- out_spike, out, 1, neuron fired on this event.
- out_state, out, WIDTH, post-update membrane value.

Function
REQ-003 Each neuron SHALL hold an independent WIDTH-bit membrane v[i] and a 4-bit refractory counter r[i]; the threshold register is shared by all neurons.
REQ-004 in_ready SHALL equal (!out_valid | out_ready); the block SHALL accept at most one event per cycle.
REQ-005 An accepted event SHALL produce its result in the output register on the next edge (latency 1), with out_valid = 1.
REQ-006 Event update when r[i] > 0: r[i] decrements by 1, v[i] stays unchanged with no leak applied, and the result has out_spike = 0.
REQ-007 Event update when r[i] = 0: sum = (v[i] - (v[i] >> LEAK_SHIFT)) + in_current, computed in WIDTH+1 bits and clamped to 2^WIDTH-1.
REQ-008 If sum >= threshold: out_spike = 1, r[i] = REFRAC, and v[i] = 0 (RESET_MODE 0) or sum - threshold (RESET_MODE 1).
REQ-009 If sum < threshold: v[i] = sum, out_spike = 0, and r[i] stays 0.
REQ-010 out_state SHALL equal the new v[i] after the update, and out_idx SHALL equal the accepted in_idx.
REQ-011 Leak SHALL be event-driven only; neurons receiving no event SHALL keep their v and r unchanged.
REQ-012 While out_valid = 1 and out_ready = 0, out_valid, out_idx, out_spike and out_state SHALL hold stable.
REQ-013 Simultaneous consume and accept: the output register SHALL reload in the same cycle, sustaining 1 event per cycle.
REQ-014 A threshold write (thr_wr = 1) SHALL take effect from the next cycle; an event accepted in the same cycle SHALL use the old threshold.
REQ-015 An accepted event with in_idx >= N_NEURONS SHALL be consumed with no state change and no output (out_valid = 0 on the next cycle unless a held result is still pending).
REQ-016 Threshold 0 SHALL make every non-refractory event spike; this case needs no special handling.

Reset
REQ-017 While rst_n = 1 at a clock edge, all v[i] and r[i] SHALL be set to 0, threshold to THRESH_INIT, and out_valid, out_spike, out_idx and out_state to 0.
REQ-018 Reset SHALL override any concurrent event or threshold write; an in-flight result is discarded.
REQ-019 in_ready SHALL read 1 in the first cycle after reset deasserts.

Verification (WIDTH = 8, LEAK_SHIFT = 1, THRESH_INIT = 200, REFRAC = 2, out_ready = 1 unless stated)
REQ-020 Integration sequence on neuron 0 with currents 100, 100, 150 SHALL give out_state 100, 150, 0 with out_spike 0, 0, 1; with RESET_MODE = 1 the third result SHALL be 25.
REQ-021 Refractory: after the spike in REQ-020, two events of 255 on neuron 0 SHALL give out_spike = 0 with v unchanged; the third such event SHALL integrate normally.
REQ-022 Saturation: write threshold 255, drive v[1] to 250, then send current 255 -> sum clamps to 255, out_spike = 1, out_state = 0.
REQ-023 Backpressure: hold out_ready = 0 with a result pending -> in_ready = 0 and the outputs stay stable for 5 cycles; releasing out_ready with back-to-back events SHALL sustain one result per cycle.
REQ-024 Independence and reset: interleaved events to neurons 0..3 SHALL each match a per-neuron reference model; asserting rst_n mid-stream SHALL return all outputs and states to 0 and the threshold to 200.
